blob_frame_streamer: RTL and testbench
======================================

Name: blob_frame_streamer

Overview:
Producer end of the blob-count pixel interface. Captures one camera frame, thresholded to 1 bit per pixel, into an on-chip bit buffer. Replays the frame to the blob counter as a contiguous one-bit-per-clock stream, framed by o_valid / o_seq. Holds o_valid until the counter returns its result, then latches the count and releases the handshake. Sits between the CCD capture / grayscale path and the blob counter.

Parameters:
IMG_COL, 800, pixels per row.
IMG_ROW, 600, rows per frame.
ADDR_W, 19, bit-buffer address width; must satisfy 2**ADDR_W >= IMG_COL*IMG_ROW.

Ports:
i_clk  in  1  clock; all logic on the rising edge.
i_rst  in  1  synchronous active-high reset.
i_trigger  in  1  one-cycle request to capture and stream a frame.
i_threshold  in  8  binarization threshold; latched on an accepted trigger.
i_frame_start  in  1  start of frame; qualifies the same-cycle pixel as pixel 0.
i_pix_valid  in  1  i_pix_gray is valid this cycle.
i_pix_gray  in  8  grayscale pixel, raster order.
o_valid  out  1  stream/frame valid to the counter.
o_seq  out  1  binary pixel to the counter.
i_count_valid  in  1  counter result valid; level, held until o_valid falls.
i_count  in  8  counter blob count.
o_count  out  8  last latched blob count.
o_count_valid  out  1  one-cycle pulse when o_count updates.
o_busy  out  1  high in every state except S_IDLE.

Behaviour:
- Reset (i_rst=1 at a clock edge): state S_IDLE; o_valid=0, o_seq=0, o_count=0, o_count_valid=0, o_busy=0. Bit-buffer contents are not cleared. Reset mid-stream aborts the stream immediately.
- N = IMG_COL*IMG_ROW. The bit buffer is a 1-bit RAM of N entries with a synchronous, 1-cycle read.
- S_IDLE: on i_trigger, latch i_threshold into thr and go to S_ARM. Triggers in any other state are ignored.
- S_ARM: wait for i_frame_start & i_pix_valid. That pixel is written at address 0, then go to S_CAPTURE with wr_addr=1.
- S_CAPTURE, each i_pix_valid cycle: write bit (i_pix_gray >= thr) at wr_addr, then wr_addr+1.
  - i_frame_start with i_pix_valid before N pixels (short frame): restart; this pixel is written at address 0 and wr_addr becomes 1.
  - After pixel N-1 is written: go to S_LAUNCH. Pixels after that are ignored.
- S_LAUNCH (1 cycle): o_valid rises (call this cycle C0); issue read of address 0; go to S_STREAM.
- S_STREAM: o_seq in cycle C0+1+k equals bit k, for k = 0..N-1. Reads are pipelined, so there are no gaps and no backpressure.
  - After bit N-1, o_seq returns to 0 and the state goes to S_WAIT.
  - o_valid stays 1 throughout.
- S_WAIT: o_valid=1, o_seq=0.
  - On i_count_valid=1: o_count <= i_count, o_count_valid=1 for exactly one cycle, o_valid <= 0 on the same edge, go to S_RELEASE.
  - No timeout: waits indefinitely.
- S_RELEASE: o_valid=0 until i_count_valid is sampled 0, then go to S_IDLE. This guarantees the counter sees o_valid low before any new frame.
- o_seq is 0 in every state except S_STREAM.
- Counters: wr_addr and rd_addr are ADDR_W wide. Terminal comparisons are against N-1, so there is no wrap.
- Minimum frame-to-frame spacing: N+4 cycles after capture completes.

Optional Feature:
BLOB_SRC_PATTERN_EN
- Defined: adds input i_pattern (1 bit), sampled with i_trigger.
  - If i_pattern=1: skip S_ARM and S_CAPTURE and go directly to S_LAUNCH. The streamed bit k is row[3]^col[3] (8x8 checkerboard, pixel (0,0)=0), generated from row/col counters, not the RAM.
  - If i_pattern=0: normal operation.
- Not defined: port absent; capture path only.

Test Plan:
- IMG_COL=8, IMG_ROW=4, thr=128; frame of gray 200 at pixel 9, else 0 -> o_valid high at C0; o_seq=1 only in cycle C0+10; 32 stream cycles total; o_seq=0 after.
- Hold i_count_valid=0 for 50 cycles after stream end, then 1 with i_count=8'd3 -> o_valid high throughout wait; same edge o_valid=0, o_count=3, o_count_valid pulses 1 cycle; S_IDLE reached 1 cycle after i_count_valid falls.
- Short frame: i_frame_start after 5 pixels, then 32 pixels with gray=pixel index*8 -> captured bit k = (k*8>=128), i.e. 1 for k>=16; first 5 pixels discarded.
- Assert i_rst in cycle C0+7 of a stream -> next cycle o_valid=0, o_seq=0, o_busy=0, o_count=0; a following i_trigger is accepted normally.
- i_trigger pulsed during S_STREAM and S_WAIT -> ignored; o_busy stays 1; exactly one stream per accepted trigger.
- With BLOB_SRC_PATTERN_EN, IMG_COL=16, IMG_ROW=16, i_pattern=1 -> no pixel input needed; o_seq at C0+1+k is (k/16)[3]^(k%16)[3]; bit 8 =1, bit 128 =1, bit 136 =0.

Source files
------------

// File: rtl/blob_frame_streamer.sv
// Frame capture into a 1-bit buffer, replayed as a one-bit-per-clock stream to the blob counter.
// Optional build macro BLOB_SRC_PATTERN_EN adds i_pattern to stream an 8x8 checkerboard instead.
module blob_frame_streamer #(
  parameter int IMG_COL = 800,
  parameter int IMG_ROW = 600,
  parameter int ADDR_W  = 19
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_trigger,
  input  logic [7:0] i_threshold,
  input  logic       i_frame_start,
  input  logic       i_pix_valid,
  input  logic [7:0] i_pix_gray,
`ifdef BLOB_SRC_PATTERN_EN
  input  logic       i_pattern,
`endif
  output logic       o_valid,
  output logic       o_seq,
  input  logic       i_count_valid,
  input  logic [7:0] i_count,
  output logic [7:0] o_count,
  output logic       o_count_valid,
  output logic       o_busy
);

  localparam int N = IMG_COL * IMG_ROW;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_LAUNCH  = 3'd3;
  localparam logic [2:0] S_STREAM  = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_RELEASE = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [7:0]        thr_q, thr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        count_q, count_d;
  logic              count_valid_q, count_valid_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_data_q;
  logic              src_bit;

  // Bit buffer: not reset, synchronous single-cycle read.
  logic mem [N];

`ifdef BLOB_SRC_PATTERN_EN
  localparam int CW = ($clog2(IMG_COL) > 4) ? $clog2(IMG_COL) : 4;
  localparam int RW = ($clog2(IMG_ROW) > 4) ? $clog2(IMG_ROW) : 4;

  logic          pat_q, pat_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
`endif

  always_comb begin
    state_d       = state_q;
    thr_d         = thr_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = wr_addr_q;
    rd_en         = 1'b0;
    rd_idx        = '0;
`ifdef BLOB_SRC_PATTERN_EN
    pat_d         = pat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_trigger) begin
          thr_d   = i_threshold;
          state_d = S_ARM;
`ifdef BLOB_SRC_PATTERN_EN
          pat_d = i_pattern;
          if (i_pattern) state_d = S_LAUNCH;
`endif
        end
      end
      S_ARM: begin
        if (i_frame_start && i_pix_valid) begin
          wr_en     = 1'b1;
          wr_idx    = '0;
          wr_addr_d = ADDR_W'(1);
          state_d   = (LAST == '0) ? S_LAUNCH : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (i_pix_valid) begin
          wr_en = 1'b1;
          // A new frame start before the buffer fills restarts the capture at pixel 0.
          if (i_frame_start) begin
            wr_idx    = '0;
            wr_addr_d = ADDR_W'(1);
          end else begin
            wr_idx    = wr_addr_q;
            wr_addr_d = wr_addr_q + 1'b1;
            if (wr_addr_q == LAST) state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        rd_en     = 1'b1;
        rd_idx    = '0;
        rd_addr_d = '0;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        // rd_addr_q is the bit on o_seq now; prefetch the next one.
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == LAST) begin
          state_d = S_WAIT;
        end else begin
          rd_en  = 1'b1;
          rd_idx = rd_addr_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (i_count_valid) begin
          count_d       = i_count;
          count_valid_d = 1'b1;
          state_d       = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Hold off until the counter drops its result so it sees o_valid low.
        if (!i_count_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BLOB_SRC_PATTERN_EN
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == S_LAUNCH) begin
      col_d = '0;
      row_d = '0;
    end else if (state_q == S_STREAM) begin
      if (col_q == CW'(IMG_COL - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign src_bit = pat_q ? (row_q[3] ^ col_q[3]) : rd_data_q;
`else
  assign src_bit = rd_data_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      thr_q         <= '0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
`ifdef BLOB_SRC_PATTERN_EN
      pat_q         <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      thr_q         <= thr_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
`ifdef BLOB_SRC_PATTERN_EN
      pat_q         <= pat_d;
      col_q         <= col_d;
      row_q         <= row_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_idx] <= (i_pix_gray >= thr_q);
    if (rd_en) rd_data_q <= mem[rd_idx];
  end

  assign o_valid       = (state_q == S_LAUNCH) || (state_q == S_STREAM) || (state_q == S_WAIT);
  assign o_seq         = (state_q == S_STREAM) && src_bit;
  assign o_busy        = (state_q != S_IDLE);
  assign o_count       = count_q;
  assign o_count_valid = count_valid_q;

endmodule

// File: tb/tb_blob_frame_streamer.sv
// Directed bench for blob_frame_streamer on an 8x4 frame (plus a 16x16 pattern instance when enabled).
module tb_blob_frame_streamer;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_trigger = 1'b0;
  logic [7:0] i_threshold = 8'd0;
  logic       i_frame_start = 1'b0;
  logic       i_pix_valid = 1'b0;
  logic [7:0] i_pix_gray = 8'd0;
  logic       i_count_valid = 1'b0;
  logic [7:0] i_count = 8'd0;
  logic       o_valid, o_seq, o_count_valid, o_busy;
  logic [7:0] o_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] frame [32];
  logic       exp_bits [32];

  always #5 clk = ~clk;

  blob_frame_streamer #(.IMG_COL(8), .IMG_ROW(4), .ADDR_W(5)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_trigger(i_trigger), .i_threshold(i_threshold),
    .i_frame_start(i_frame_start), .i_pix_valid(i_pix_valid), .i_pix_gray(i_pix_gray),
`ifdef BLOB_SRC_PATTERN_EN
    .i_pattern(1'b0),
`endif
    .o_valid(o_valid), .o_seq(o_seq), .i_count_valid(i_count_valid), .i_count(i_count),
    .o_count(o_count), .o_count_valid(o_count_valid), .o_busy(o_busy)
  );

`ifdef BLOB_SRC_PATTERN_EN
  logic       p_trigger = 1'b0;
  logic       p_count_valid = 1'b0;
  logic       p_valid, p_seq, p_count_valid_o, p_busy;
  logic [7:0] p_count;

  blob_frame_streamer #(.IMG_COL(16), .IMG_ROW(16), .ADDR_W(8)) u_pat (
    .i_clk(clk), .i_rst(i_rst), .i_trigger(p_trigger), .i_threshold(i_threshold),
    .i_frame_start(i_frame_start), .i_pix_valid(i_pix_valid), .i_pix_gray(i_pix_gray),
    .i_pattern(1'b1),
    .o_valid(p_valid), .o_seq(p_seq), .i_count_valid(p_count_valid), .i_count(i_count),
    .o_count(p_count), .o_count_valid(p_count_valid_o), .o_busy(p_busy)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trigger, then feed frame[0..31] with frame start on pixel 0; returns in cycle C0.
  task automatic capture_frame(input logic [7:0] thr);
    i_trigger = 1'b1;
    i_threshold = thr;
    tick();
    i_trigger = 1'b0;
    for (int p = 0; p < 32; p++) begin
      i_pix_valid = 1'b1;
      i_frame_start = (p == 0);
      i_pix_gray = frame[p];
      tick();
    end
    i_pix_valid = 1'b0;
    i_frame_start = 1'b0;
    i_pix_gray = 8'd0;
  endtask

  // Starts in C0, checks all 32 stream bits, ends in the first S_WAIT cycle.
  task automatic check_stream(input string tag);
    checks++;
    if (o_valid !== 1'b1 || o_seq !== 1'b0) begin
      failures++;
      $display("FAIL %s_c0 valid=%b seq=%b expected valid=1 seq=0", tag, o_valid, o_seq);
    end
    for (int k = 0; k < 32; k++) begin
      tick();
      checks++;
      if (o_seq !== exp_bits[k] || o_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s_bit%0d seq=%b valid=%b expected seq=%b valid=1", tag, k, o_seq, o_valid, exp_bits[k]);
      end
    end
    tick();
    checks++;
    if (o_seq !== 1'b0 || o_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_after seq=%b valid=%b expected seq=0 valid=1", tag, o_seq, o_valid);
    end
  endtask

  task automatic handshake(input string tag, input logic [7:0] cnt);
    i_count_valid = 1'b1;
    i_count = cnt;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_count !== cnt || o_count_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_latch valid=%b count=%0d cv=%b expected valid=0 count=%0d cv=1",
               tag, o_valid, o_count, o_count_valid, cnt);
    end
    tick();
    checks++;
    if (o_count_valid !== 1'b0 || o_busy !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_release cv=%b busy=%b valid=%b expected cv=0 busy=1 valid=0",
               tag, o_count_valid, o_busy, o_valid);
    end
    i_count_valid = 1'b0;
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_count !== cnt) begin
      failures++;
      $display("FAIL %s_idle busy=%b count=%0d expected busy=0 count=%0d", tag, o_busy, o_count, cnt);
    end
  endtask

  task automatic load_single_hot();
    for (int i = 0; i < 32; i++) begin
      frame[i] = (i == 9) ? 8'd200 : 8'd0;
      exp_bits[i] = (i == 9);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_seq !== 1'b0 || o_count !== 8'd0 || o_count_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset valid=%b seq=%b count=%0d cv=%b busy=%b expected all 0",
               o_valid, o_seq, o_count, o_count_valid, o_busy);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_stream();
    load_single_hot();
    capture_frame(8'd128);
    check_stream("basic");
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_seq !== 1'b0 || o_busy !== 1'b1) begin
        failures++;
        $display("FAIL wait_hold%0d valid=%b seq=%b busy=%b expected 1 0 1", c, o_valid, o_seq, o_busy);
      end
    end
    handshake("basic", 8'd3);
  endtask

  task automatic test_short_frame();
    i_trigger = 1'b1;
    i_threshold = 8'd128;
    tick();
    i_trigger = 1'b0;
    for (int p = 0; p < 5; p++) begin
      i_pix_valid = 1'b1;
      i_frame_start = (p == 0);
      i_pix_gray = 8'd255;
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      frame[i] = 8'(i * 8);
      exp_bits[i] = (i >= 16);
    end
    for (int p = 0; p < 32; p++) begin
      i_pix_valid = 1'b1;
      i_frame_start = (p == 0);
      i_pix_gray = frame[p];
      tick();
    end
    i_pix_valid = 1'b0;
    i_frame_start = 1'b0;
    i_pix_gray = 8'd0;
    check_stream("short");
    handshake("short", 8'd7);
  endtask

  task automatic test_reset_mid_stream();
    load_single_hot();
    capture_frame(8'd128);
    for (int c = 0; c < 7; c++) tick();
    i_rst = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_seq !== 1'b0 || o_busy !== 1'b0 || o_count !== 8'd0) begin
      failures++;
      $display("FAIL midreset valid=%b seq=%b busy=%b count=%0d expected 0 0 0 0",
               o_valid, o_seq, o_busy, o_count);
    end
    i_rst = 1'b0;
    tick();
    capture_frame(8'd128);
    check_stream("postreset");
    handshake("postreset", 8'd5);
  endtask

  task automatic test_ignored_trigger();
    load_single_hot();
    capture_frame(8'd128);
    for (int k = 0; k < 32; k++) begin
      i_trigger = (k == 3);
      tick();
      checks++;
      if (o_seq !== exp_bits[k] || o_busy !== 1'b1) begin
        failures++;
        $display("FAIL ign_bit%0d seq=%b busy=%b expected seq=%b busy=1", k, o_seq, o_busy, exp_bits[k]);
      end
    end
    i_trigger = 1'b1;
    tick();
    i_trigger = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_seq !== 1'b0) begin
      failures++;
      $display("FAIL ign_wait valid=%b busy=%b seq=%b expected 1 1 0", o_valid, o_busy, o_seq);
    end
    handshake("ign", 8'd9);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
        failures++;
        $display("FAIL ign_idle%0d busy=%b valid=%b expected 0 0", c, o_busy, o_valid);
      end
    end
  endtask

`ifdef BLOB_SRC_PATTERN_EN
  task automatic test_pattern();
    logic exp;
    p_trigger = 1'b1;
    tick();
    p_trigger = 1'b0;
    checks++;
    if (p_valid !== 1'b1 || p_seq !== 1'b0) begin
      failures++;
      $display("FAIL pat_c0 valid=%b seq=%b expected 1 0", p_valid, p_seq);
    end
    for (int k = 0; k < 256; k++) begin
      tick();
      exp = ((k / 16) >= 8) ^ ((k % 16) >= 8);
      checks++;
      if (p_seq !== exp || p_valid !== 1'b1) begin
        failures++;
        $display("FAIL pat_bit%0d seq=%b valid=%b expected seq=%b valid=1", k, p_seq, p_valid, exp);
      end
    end
    tick();
    checks++;
    if (p_seq !== 1'b0 || p_valid !== 1'b1) begin
      failures++;
      $display("FAIL pat_after seq=%b valid=%b expected 0 1", p_seq, p_valid);
    end
    p_count_valid = 1'b1;
    tick();
    p_count_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (p_busy !== 1'b0 || p_valid !== 1'b0) begin
      failures++;
      $display("FAIL pat_idle busy=%b valid=%b expected 0 0", p_busy, p_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_stream();
    test_short_frame();
    test_reset_mid_stream();
    test_ignored_trigger();
`ifdef BLOB_SRC_PATTERN_EN
    test_pattern();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
